// File: rtl/gpu_cpu2vram_xfer_ctrl_if.sv
// CPU-to-VRAM upload bundle: pixel FIFO read side plus VRAM write port.
// master = transfer controller, slave = FIFO/arbiter side.
interface gpu_cpu2vram_xfer_ctrl_if #(
    parameter int XW = 10,
    parameter int YW = 9
);
    logic          fifo_valid0;
    logic [15:0]   fifo_data0;
    logic          fifo_valid1;
    logic [15:0]   fifo_data1;
    logic          fifo_pop0;
    logic          fifo_pop1;
    logic          fifo_flush;
    logic          wr_req;
    logic          wr_ack;
    logic [XW-1:0] wr_x;
    logic [YW-1:0] wr_y;
    logic [31:0]   wr_data;
    logic [1:0]    wr_be;

    modport master (
        input  fifo_valid0, fifo_data0, fifo_valid1, fifo_data1,
        input  wr_ack,
        output fifo_pop0, fifo_pop1, fifo_flush,
        output wr_req, wr_x, wr_y, wr_data, wr_be
    );

    modport slave (
        output fifo_valid0, fifo_data0, fifo_valid1, fifo_data1,
        output wr_ack,
        input  fifo_pop0, fifo_pop1, fifo_flush,
        input  wr_req, wr_x, wr_y, wr_data, wr_be
    );
endinterface

// File: rtl/gpu_cpu2vram_xfer_ctrl.sv
// CPU-to-VRAM rectangle upload: drains the pixel FIFO and walks the
// destination rectangle with VRAM wrap, issuing 1/2-pixel writes.
module gpu_cpu2vram_xfer_ctrl #(
    parameter int XW = 10,
    parameter int YW = 9
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [XW-1:0] x_i,
    input  logic [YW-1:0] y_i,
    input  logic [XW-1:0] w_i,
    input  logic [YW-1:0] h_i,
    input  logic          set_mask_i,
    input  logic          abort_i,
    gpu_cpu2vram_xfer_ctrl_if.master bus,
    output logic          busy_o,
    output logic          done_o
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_WRITE,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [XW-1:0] x0_q, cur_x_q;
    logic [YW-1:0] y_q;
    logic [XW:0]   wr_rem_q, col_rem_q;
    logic [YW:0]   hgt_rem_q;
    logic          flush_q;
    logic [XW-1:0] wr_x_q;
    logic [YW-1:0] wr_y_q;
    logic [31:0]   wr_data_q;
    logic [1:0]    wr_be_q;

    logic          pair_ok, take_pair, take_single, ack_fire;
    logic          row_end, last_row;
    logic [XW:0]   step, col_nxt, w_full;
    logic [YW:0]   h_full;
    logic [15:0]   msk;

    // Zero width/height encode the full VRAM extent.
    assign w_full = (w_i == '0) ? {1'b1, {XW{1'b0}}} : {1'b0, w_i};
    assign h_full = (h_i == '0) ? {1'b1, {YW{1'b0}}} : {1'b0, h_i};
    assign msk    = {set_mask_i, 15'h0};

    // A pair may not straddle the right edge of VRAM.
    assign pair_ok = (col_rem_q >= (XW+1)'(2)) && (cur_x_q != '1);
    assign take_pair = (state_q == S_FETCH) && !abort_i
                       && pair_ok && bus.fifo_valid1;
    assign take_single = (state_q == S_FETCH) && !abort_i
                         && !pair_ok && bus.fifo_valid0;
    assign ack_fire = (state_q == S_WRITE) && !abort_i && bus.wr_ack;

    assign step     = wr_be_q[1] ? (XW+1)'(2) : (XW+1)'(1);
    assign col_nxt  = col_rem_q - step;
    assign row_end  = (col_nxt == '0);
    assign last_row = row_end && (hgt_rem_q == (YW+1)'(1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (abort_i) state_d = S_IDLE;
                else if (take_pair || take_single) state_d = S_WRITE;
            end
            S_WRITE: begin
                if (abort_i) state_d = S_IDLE;
                else if (ack_fire) state_d = last_row ? S_DONE : S_FETCH;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x0_q      <= '0;
            cur_x_q   <= '0;
            y_q       <= '0;
            wr_rem_q  <= '0;
            col_rem_q <= '0;
            hgt_rem_q <= '0;
            flush_q   <= 1'b0;
            wr_x_q    <= '0;
            wr_y_q    <= '0;
            wr_data_q <= '0;
            wr_be_q   <= '0;
        end else begin
            flush_q <= abort_i && (state_q != S_IDLE);
            if ((state_q == S_IDLE) && start_i) begin
                x0_q      <= x_i;
                cur_x_q   <= x_i;
                y_q       <= y_i;
                wr_rem_q  <= w_full;
                col_rem_q <= w_full;
                hgt_rem_q <= h_full;
            end
            if (take_pair) begin
                wr_x_q    <= cur_x_q;
                wr_y_q    <= y_q;
                wr_data_q <= {bus.fifo_data1 | msk, bus.fifo_data0 | msk};
                wr_be_q   <= 2'b11;
            end else if (take_single) begin
                wr_x_q    <= cur_x_q;
                wr_y_q    <= y_q;
                wr_data_q <= {16'h0, bus.fifo_data0 | msk};
                wr_be_q   <= 2'b01;
            end
            if (ack_fire) begin
                if (row_end) begin
                    cur_x_q   <= x0_q;
                    col_rem_q <= wr_rem_q;
                    y_q       <= y_q + 1'b1;
                    hgt_rem_q <= hgt_rem_q - 1'b1;
                end else begin
                    cur_x_q   <= cur_x_q + step[XW-1:0];
                    col_rem_q <= col_nxt;
                end
            end
        end
    end

    assign bus.fifo_pop0  = take_pair || take_single;
    assign bus.fifo_pop1  = take_pair;
    assign bus.fifo_flush = flush_q;
    assign bus.wr_req     = (state_q == S_WRITE);
    assign bus.wr_x       = wr_x_q;
    assign bus.wr_y       = wr_y_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.wr_be      = wr_be_q;
    assign busy_o         = (state_q != S_IDLE);
    assign done_o         = (state_q == S_DONE);
endmodule

// File: tb/tb_gpu_cpu2vram_xfer_ctrl.sv
// Scoreboard bench for gpu_cpu2vram_xfer_ctrl: queue-modelled FIFO,
// auto/manual ack arbiter, monitor comparing every presented write.
module tb_gpu_cpu2vram_xfer_ctrl;
    localparam int XW = 10;
    localparam int YW = 9;

    typedef struct packed {
        logic [9:0]  x;
        logic [8:0]  y;
        logic [31:0] d;
        logic [1:0]  be;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       set_mask = 1'b0;
    logic       abort = 1'b0;
    logic [9:0] x = '0;
    logic [9:0] w = '0;
    logic [8:0] y = '0;
    logic [8:0] h = '0;
    logic       busy, done;

    always #5 clk = ~clk;

    gpu_cpu2vram_xfer_ctrl_if #(.XW(XW), .YW(YW)) bus ();

    gpu_cpu2vram_xfer_ctrl #(.XW(XW), .YW(YW)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .x_i        (x),
        .y_i        (y),
        .w_i        (w),
        .h_i        (h),
        .set_mask_i (set_mask),
        .abort_i    (abort),
        .bus        (bus),
        .busy_o     (busy),
        .done_o     (done)
    );

    int pass_n = 0;
    int total_n = 0;
    int done_cnt = 0;
    int flush_cnt = 0;
    int pop1_cnt = 0;
    int wr_cnt = 0;
    int req_cyc = 0;
    logic [15:0] fq[$];
    wr_t exp_q[$];
    wr_t mon_e;
    bit ack_auto = 1'b1;
    bit ack_man = 1'b0;
    int stall_n = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] expv);
        total_n++;
        if (got === expv) pass_n++;
        else $display("FAIL %s got=%h exp=%h t=%0t", nm, got, expv, $time);
    endtask

    task automatic add_exp(input logic [9:0] xx, input logic [8:0] yy,
                           input logic [31:0] dd, input logic [1:0] bb);
        wr_t e;
        e.x = xx; e.y = yy; e.d = dd; e.be = bb;
        exp_q.push_back(e);
    endtask

    // FIFO model: pops seen at negedge take effect after the next posedge.
    initial begin
        bit p0, p1, fl;
        bus.fifo_valid0 = 1'b0;
        bus.fifo_valid1 = 1'b0;
        bus.fifo_data0  = '0;
        bus.fifo_data1  = '0;
        forever begin
            @(negedge clk);
            p0 = bus.fifo_pop0;
            p1 = bus.fifo_pop1;
            fl = bus.fifo_flush;
            @(posedge clk);
            #2;
            if (fl) fq.delete();
            if (p0) begin
                chk("pop0_nonempty", 32'(fq.size() > 0), 1);
                if (fq.size() > 0) void'(fq.pop_front());
            end
            if (p1) begin
                chk("pop1_nonempty", 32'(fq.size() > 0), 1);
                if (fq.size() > 0) void'(fq.pop_front());
            end
            bus.fifo_valid0 = (fq.size() >= 1);
            bus.fifo_valid1 = (fq.size() >= 2);
            bus.fifo_data0  = (fq.size() >= 1) ? fq[0] : 16'h0;
            bus.fifo_data1  = (fq.size() >= 2) ? fq[1] : 16'h0;
        end
    end

    initial begin
        bus.wr_ack = 1'b0;
        forever begin
            @(posedge clk);
            #3;
            if (!ack_auto) begin
                bus.wr_ack = ack_man;
            end else if (bus.wr_req) begin
                if (stall_n > 0) begin
                    stall_n--;
                    bus.wr_ack = 1'b0;
                end else begin
                    bus.wr_ack = 1'b1;
                end
            end else begin
                bus.wr_ack = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.wr_req) begin
                req_cyc++;
                if (exp_q.size() == 0) begin
                    chk("req_unexpected", 32'(bus.wr_req), 0);
                end else begin
                    mon_e = exp_q[0];
                    chk("wr_x", 32'(bus.wr_x), 32'(mon_e.x));
                    chk("wr_y", 32'(bus.wr_y), 32'(mon_e.y));
                    chk("wr_data", bus.wr_data, mon_e.d);
                    chk("wr_be", 32'(bus.wr_be), 32'(mon_e.be));
                    chk("pop_during_req",
                        32'({bus.fifo_pop1, bus.fifo_pop0}), 0);
                    if (bus.wr_ack) begin
                        void'(exp_q.pop_front());
                        if (!abort) wr_cnt++;
                    end
                end
            end
            if (done) done_cnt++;
            if (bus.fifo_flush) flush_cnt++;
            if (bus.fifo_pop1) begin
                pop1_cnt++;
                chk("pop1_with_pop0", 32'(bus.fifo_pop0), 1);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_xfer(input logic [9:0] xx, input logic [8:0] yy,
                              input logic [9:0] ww, input logic [8:0] hh,
                              input bit abt);
        @(posedge clk);
        #1;
        x = xx; y = yy; w = ww; h = hh;
        start = 1'b1;
        abort = abt;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (!busy && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk(nm, 32'(ok), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, f0, w0, p1c, r0;
        bit seen;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_req", 32'(bus.wr_req), 0);
        chk("rst_pops", 32'({bus.fifo_pop1, bus.fifo_pop0}), 0);
        chk("rst_flush", 32'(bus.fifo_flush), 0);
        chk("rst_wr_be", 32'(bus.wr_be), 0);
        chk("rst_wr_data", bus.wr_data, 0);
        rst = 1'b0;
        cyc(2);

        // 4x2 rectangle at origin, FIFO preloaded
        for (int i = 1; i <= 8; i++) fq.push_back(16'h0100 + 16'(i));
        add_exp(0, 0, 32'h0102_0101, 2'b11);
        add_exp(2, 0, 32'h0104_0103, 2'b11);
        add_exp(0, 1, 32'h0106_0105, 2'b11);
        add_exp(2, 1, 32'h0108_0107, 2'b11);
        d0 = done_cnt;
        w0 = wr_cnt;
        start_xfer(0, 0, 4, 2, 1'b0);
        chk("t1_busy_after_start", 32'(busy), 1);
        cyc(1);
        chk("t1_latency_req", 32'(bus.wr_req), 1);
        wait_idle(100, "t1_idle");
        chk("t1_done_once", 32'(done_cnt - d0), 1);
        chk("t1_writes", 32'(wr_cnt - w0), 4);
        chk("t1_busy_low", 32'(busy), 0);

        // x and y wrap
        fq.push_back(16'hAAAA);
        fq.push_back(16'hBBBB);
        fq.push_back(16'hCCCC);
        add_exp(1022, 511, 32'hBBBB_AAAA, 2'b11);
        add_exp(0, 511, 32'h0000_CCCC, 2'b01);
        d0 = done_cnt;
        start_xfer(1022, 511, 3, 1, 1'b0);
        wait_idle(100, "t2_idle");
        chk("t2_done_once", 32'(done_cnt - d0), 1);

        // row starting at the last column
        p1c = pop1_cnt;
        fq.push_back(16'h1111);
        fq.push_back(16'h2222);
        add_exp(1023, 5, 32'h0000_1111, 2'b01);
        add_exp(0, 5, 32'h0000_2222, 2'b01);
        start_xfer(1023, 5, 2, 1, 1'b0);
        wait_idle(100, "t3_idle");
        chk("t3_no_pop1", 32'(pop1_cnt - p1c), 0);

        // mask bit with a 5-cycle ack stall
        set_mask = 1'b1;
        stall_n = 5;
        r0 = req_cyc;
        fq.push_back(16'h1234);
        fq.push_back(16'h0001);
        add_exp(10, 3, 32'h8001_9234, 2'b11);
        start_xfer(10, 3, 2, 1, 1'b0);
        wait_idle(100, "t4_idle");
        chk("t4_req_cycles", 32'(req_cyc - r0), 6);
        set_mask = 1'b0;

        // FIFO starvation mid-row, odd width
        fq.push_back(16'h0A00);
        fq.push_back(16'h0A01);
        add_exp(100, 7, 32'h0A01_0A00, 2'b11);
        add_exp(102, 7, 32'h0A03_0A02, 2'b11);
        add_exp(104, 7, 32'h0000_0A04, 2'b01);
        start_xfer(100, 7, 5, 1, 1'b0);
        cyc(3);
        repeat (4) begin
            cyc(1);
            chk("t5_starved_req", 32'(bus.wr_req), 0);
        end
        fq.push_back(16'h0A02);
        repeat (4) begin
            cyc(1);
            chk("t5_pair_waits", 32'(bus.wr_req), 0);
        end
        fq.push_back(16'h0A03);
        fq.push_back(16'h0A04);
        wait_idle(100, "t5_idle");

        // width 1, start together with abort in IDLE
        f0 = flush_cnt;
        d0 = done_cnt;
        fq.push_back(16'h7FFF);
        fq.push_back(16'h0005);
        add_exp(50, 20, 32'h0000_7FFF, 2'b01);
        add_exp(50, 21, 32'h0000_0005, 2'b01);
        start_xfer(50, 20, 1, 2, 1'b1);
        wait_idle(100, "t6_idle");
        chk("t6_done_once", 32'(done_cnt - d0), 1);
        chk("t6_start_beats_abort", 32'(flush_cnt - f0), 0);

        // abort while idle
        f0 = flush_cnt;
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        cyc(1);
        chk("t7_idle_abort_flush", 32'(flush_cnt - f0), 0);
        chk("t7_idle_abort_busy", 32'(busy), 0);

        // abort in WRITE with ack in the same cycle
        ack_auto = 1'b0;
        ack_man = 1'b0;
        for (int i = 0; i < 4; i++) fq.push_back(16'hC000 + 16'(i));
        add_exp(200, 9, 32'hC001_C000, 2'b11);
        d0 = done_cnt;
        f0 = flush_cnt;
        w0 = wr_cnt;
        start_xfer(200, 9, 4, 1, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.wr_req) begin
                seen = 1'b1;
                break;
            end
            cyc(1);
        end
        chk("t8_req_seen", 32'(seen), 1);
        ack_man = 1'b1;
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        ack_man = 1'b0;
        chk("t8_busy_low", 32'(busy), 0);
        chk("t8_req_low", 32'(bus.wr_req), 0);
        chk("t8_flush_pulse", 32'(bus.fifo_flush), 1);
        cyc(1);
        chk("t8_flush_one_cycle", 32'(bus.fifo_flush), 0);
        chk("t8_no_done", 32'(done_cnt - d0), 0);
        chk("t8_no_write", 32'(wr_cnt - w0), 0);
        chk("t8_flush_count", 32'(flush_cnt - f0), 1);
        cyc(2);
        chk("t8_fifo_flushed", 32'(fq.size()), 0);
        ack_auto = 1'b1;
        cyc(2);

        // w=0/h=0: a full 1024-pixel row, then the next line begins
        for (int i = 0; i < 1026; i++) fq.push_back(16'(i));
        for (int k = 0; k < 512; k++)
            add_exp(10'(2 * k), 0, {16'(2 * k + 1), 16'(2 * k)}, 2'b11);
        add_exp(0, 1, {16'(1025), 16'(1024)}, 2'b11);
        d0 = done_cnt;
        start_xfer(0, 0, 0, 0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            cyc(1);
            if (exp_q.size() == 0) begin
                seen = 1'b1;
                break;
            end
        end
        chk("t9_drained", 32'(seen), 1);
        chk("t9_still_busy", 32'(busy), 1);
        chk("t9_no_done", 32'(done_cnt - d0), 0);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        chk("t9_abort_busy", 32'(busy), 0);
        cyc(3);

        chk("exp_queue_empty", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
